cpu_control_fsm: RTL and testbench
==================================

Name: cpu_control_fsm

Overview:
- Moore controller that sequences the 16-bit RISC core. It is the initiator for the control interface that the datapath, instruction register, PC counter and RAM respond to.
- Takes opcode/op from the decoder (fed by the instruction register).
- Drives every load, select and write strobe through fetch, decode, execute and writeback.
- Sits beside the decoder in top. Replaces the currently undriven control wires.

Parameters:
- none (encodings are fixed by the ISA)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- opcode  in  3  instruction[15:13] from decoder
- op  in  2  instruction[12:11] from decoder
- nsel  out  3  register-number select, one-hot: 001=Rn, 010=Rd, 100=Rm
- loada, loadb, loadc, loads  out  1 each  datapath register loads
- asel  out  1  1 = A operand forced to 0
- bsel  out  1  1 = B operand is sximm5
- vsel  out  2  writeback source: 00=datapath_out(C), 01=sximm8, 10=mdata
- write  out  1  register-file write enable
- loadir  out  1  instruction-register load
- loadpc  out  1  PC increment
- pc_clear  out  1  synchronous clear to counter
- msel  out  1  RAM address: 0=PC, 1=C
- mwrite  out  1  RAM write enable
- halted  out  1  core stopped

Behaviour:
- Moore machine: all outputs decoded from the state register only. Any output not listed for a state is 0.
- Async reset forces state RESET immediately, including mid-instruction. Outputs then: pc_clear=1, everything else 0, halted=0.
- Next-state and per-state outputs:
  - RESET: pc_clear=1 -> FETCH_ADDR.
  - FETCH_ADDR: msel=0 (synchronous RAM read launched) -> FETCH_IR.
  - FETCH_IR: msel=0, loadir=1 -> PC_INC.
  - PC_INC: loadpc=1 -> DECODE.
  - DECODE: no strobes. Branch on {opcode,op}:
    - 110_10 MOV imm -> WR_IMM
    - 110_00 MOV reg -> GET_B
    - 101_xx ALU -> GET_A
    - 011_00 LDR -> GET_A
    - 100_00 STR -> GET_A
    - 111_xx HALT -> HALT
    - anything else is a NOP -> FETCH_ADDR
  - WR_IMM: nsel=Rn, vsel=01, write=1 -> FETCH_ADDR.
  - GET_A: nsel=Rn, loada=1 -> GET_B for ALU; -> ADDR for LDR/STR.
  - GET_B: nsel=Rm, loadb=1 -> EXEC.
  - EXEC:
    - asel=1 for MOV reg, else 0; bsel=0.
    - CMP (op=01): loads=1, loadc=0 -> FETCH_ADDR.
    - Otherwise: loadc=1 -> WR_C.
  - WR_C: nsel=Rd, vsel=00, write=1 -> FETCH_ADDR.
  - ADDR: asel=0, bsel=1, loadc=1 (C=Rn+sximm5) -> MEM_RD for LDR; -> GET_D for STR.
  - MEM_RD: msel=1 -> LD_WR.
  - LD_WR: msel=1, nsel=Rd, vsel=10, write=1 -> FETCH_ADDR.
  - GET_D: nsel=Rd, loadb=1 -> MEM_WR.
  - MEM_WR: msel=1, mwrite=1 (RAM in = B) -> FETCH_ADDR.
  - HALT: halted=1. Sticky; only reset leaves it.
- ALUop is passed straight from the decoder; the controller does not drive it.
- Cycle counts, FETCH_ADDR to next FETCH_ADDR: MOV imm 5, MOV reg 7, ADD/AND/MVN 8, CMP 7, LDR 8, STR 8, NOP 4.
- The opcode/op branch is taken only in DECODE and in the states that branch on instruction type. Inputs are stable from the IR at those points and are ignored in all other states.
- At most one of write/mwrite/loadir/loadpc is asserted in any state.
- State encoding is free. Unreachable encodings must recover to RESET on the next clock.

Optional Feature:
- Macro: CTRL_RETIRE_COUNT_EN.
- Defined: adds output retired[15:0].
  - Cleared by reset.
  - Increments by 1 on every clock that leaves WR_IMM, WR_C, LD_WR, MEM_WR, EXEC(CMP), or DECODE(NOP) into FETCH_ADDR.
  - Wraps 0xFFFF -> 0x0000. Never increments in HALT.
- Undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset pulse mid-GET_B -> outputs go to the RESET state set (pc_clear=1, all others 0) the same cycle without a clock; first clock after release -> FETCH_ADDR, msel=0.
- Fetch opcode=110 op=10 (MOV imm) -> loadir on cycle 2, loadpc cycle 3, write=1 with vsel=01 and nsel=001 on cycle 5, then FETCH_ADDR.
- opcode=101 op=01 (CMP) -> loada/nsel=001 then loadb/nsel=100 then loads=1 with loadc=0, write never asserted; 7 cycles total.
- LDR (011_00) -> ADDR cycle with bsel=1 and loadc=1, MEM_RD msel=1, LD_WR write=1 with vsel=10 and nsel=010; 8 cycles. STR (100_00) -> GET_D loadb with nsel=010, then mwrite=1 with msel=1.
- opcode=111 -> halted=1 held for 20 clocks with no strobes; assert reset -> halted=0 and restart from RESET.
- With CTRL_RETIRE_COUNT_EN: preload retired to 0xFFFF via 65535 MOV imm instructions (or force), retire one more instruction -> 0x0000; undefined opcode 001 counts as 1 NOP.

Source files
------------

// File: rtl/cpu_control_fsm.sv
// Moore sequencer for the 16-bit RISC core: fetch, decode, execute and writeback strobes.
// Define CTRL_RETIRE_COUNT_EN to add the 16-bit retired-instruction counter output.
module cpu_control_fsm (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  opcode,
  input  logic [1:0]  op,
  output logic [2:0]  nsel,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  vsel,
  output logic        write,
  output logic        loadir,
  output logic        loadpc,
  output logic        pc_clear,
  output logic        msel,
  output logic        mwrite,
  output logic        halted
`ifdef CTRL_RETIRE_COUNT_EN
  ,
  output logic [15:0] retired
`endif
);

  typedef enum logic [3:0] {
    S_RESET, S_FETCH_ADDR, S_FETCH_IR, S_PC_INC, S_DECODE, S_WR_IMM, S_GET_A, S_GET_B,
    S_EXEC, S_WR_C, S_ADDR, S_MEM_RD, S_LD_WR, S_GET_D, S_MEM_WR, S_HALT
  } state_t;

  typedef struct packed {
    logic [2:0] nsel;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic       bsel;
    logic [1:0] vsel;
    logic       write;
    logic       loadir;
    logic       loadpc;
    logic       pc_clear;
    logic       msel;
    logic       mwrite;
    logic       halted;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = ctrl_t'(18'd0);

  state_t state_r;
  state_t state_next_s;
  ctrl_t  ctrl_r;

  // Strobe set for a state; instruction fields matter only in EXEC (MOV reg / CMP variants).
  function automatic ctrl_t decode_ctrl(input state_t s, input logic [2:0] opc, input logic [1:0] o);
    ctrl_t c;
    c = CTRL_NONE;
    case (s)
      S_RESET:      c.pc_clear = 1'b1;
      S_FETCH_ADDR: c.msel = 1'b0;
      S_FETCH_IR:   c.loadir = 1'b1;
      S_PC_INC:     c.loadpc = 1'b1;
      S_DECODE:     c = CTRL_NONE;
      S_WR_IMM:     begin c.nsel = 3'b001; c.vsel = 2'b01; c.write = 1'b1; end
      S_GET_A:      begin c.nsel = 3'b001; c.loada = 1'b1; end
      S_GET_B:      begin c.nsel = 3'b100; c.loadb = 1'b1; end
      S_EXEC: begin
        c.asel = (opc == 3'b110);
        if ((opc == 3'b101) && (o == 2'b01)) c.loads = 1'b1;
        else                                 c.loadc = 1'b1;
      end
      S_WR_C:       begin c.nsel = 3'b010; c.write = 1'b1; end
      S_ADDR:       begin c.bsel = 1'b1; c.loadc = 1'b1; end
      S_MEM_RD:     c.msel = 1'b1;
      S_LD_WR:      begin c.msel = 1'b1; c.nsel = 3'b010; c.vsel = 2'b10; c.write = 1'b1; end
      S_GET_D:      begin c.nsel = 3'b010; c.loadb = 1'b1; end
      S_MEM_WR:     begin c.msel = 1'b1; c.mwrite = 1'b1; end
      S_HALT:       c.halted = 1'b1;
      default:      c = CTRL_NONE;
    endcase
    return c;
  endfunction

  // Next-state logic; instruction fields are consulted only in the branching states.
  always_comb begin
    state_next_s = S_RESET;
    case (state_r)
      S_RESET:      state_next_s = S_FETCH_ADDR;
      S_FETCH_ADDR: state_next_s = S_FETCH_IR;
      S_FETCH_IR:   state_next_s = S_PC_INC;
      S_PC_INC:     state_next_s = S_DECODE;
      S_DECODE: begin
        casez ({opcode, op})
          5'b110_10: state_next_s = S_WR_IMM;
          5'b110_00: state_next_s = S_GET_B;
          5'b101_??: state_next_s = S_GET_A;
          5'b011_00: state_next_s = S_GET_A;
          5'b100_00: state_next_s = S_GET_A;
          5'b111_??: state_next_s = S_HALT;
          default:   state_next_s = S_FETCH_ADDR;
        endcase
      end
      S_WR_IMM:     state_next_s = S_FETCH_ADDR;
      S_GET_A: begin
        if (opcode == 3'b101) state_next_s = S_GET_B;
        else                  state_next_s = S_ADDR;
      end
      S_GET_B:      state_next_s = S_EXEC;
      S_EXEC: begin
        if ((opcode == 3'b101) && (op == 2'b01)) state_next_s = S_FETCH_ADDR;
        else                                     state_next_s = S_WR_C;
      end
      S_WR_C:       state_next_s = S_FETCH_ADDR;
      S_ADDR: begin
        if (opcode == 3'b011) state_next_s = S_MEM_RD;
        else                  state_next_s = S_GET_D;
      end
      S_MEM_RD:     state_next_s = S_LD_WR;
      S_LD_WR:      state_next_s = S_FETCH_ADDR;
      S_GET_D:      state_next_s = S_MEM_WR;
      S_MEM_WR:     state_next_s = S_FETCH_ADDR;
      S_HALT:       state_next_s = S_HALT;
      default:      state_next_s = S_RESET;
    endcase
  end

  // State register plus registered strobes, which always equal decode_ctrl(state_r).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_RESET;
      ctrl_r  <= decode_ctrl(S_RESET, 3'b000, 2'b00);
    end else begin
      state_r <= state_next_s;
      ctrl_r  <= decode_ctrl(state_next_s, opcode, op);
    end
  end

  assign nsel     = ctrl_r.nsel;
  assign loada    = ctrl_r.loada;
  assign loadb    = ctrl_r.loadb;
  assign loadc    = ctrl_r.loadc;
  assign loads    = ctrl_r.loads;
  assign asel     = ctrl_r.asel;
  assign bsel     = ctrl_r.bsel;
  assign vsel     = ctrl_r.vsel;
  assign write    = ctrl_r.write;
  assign loadir   = ctrl_r.loadir;
  assign loadpc   = ctrl_r.loadpc;
  assign pc_clear = ctrl_r.pc_clear;
  assign msel     = ctrl_r.msel;
  assign mwrite   = ctrl_r.mwrite;
  assign halted   = ctrl_r.halted;

`ifdef CTRL_RETIRE_COUNT_EN
  logic        retire_s;
  logic [15:0] retired_r;

  // Every return to FETCH_ADDR other than the one out of RESET completes an instruction.
  assign retire_s = (state_next_s == S_FETCH_ADDR) && (state_r != S_RESET);

  // Retired-instruction counter, wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         retired_r <= 16'd0;
    else if (retire_s) retired_r <= retired_r + 16'd1;
    else               retired_r <= retired_r;
  end

  assign retired = retired_r;
`endif

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Scoreboard bench for cpu_control_fsm: per-cycle expected strobe vectors queued by stimulus,
// popped and compared by a negedge monitor. Retire counter checks need CTRL_RETIRE_COUNT_EN.
module tb_cpu_control_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  opcode;
  logic [1:0]  op;
  logic [2:0]  nsel;
  logic        loada, loadb, loadc, loads, asel, bsel;
  logic [1:0]  vsel;
  logic        write, loadir, loadpc, pc_clear, msel, mwrite, halted;
`ifdef CTRL_RETIRE_COUNT_EN
  logic [15:0] retired;
`endif

  cpu_control_fsm dut (
    .clk(clk), .reset(reset), .opcode(opcode), .op(op),
    .nsel(nsel), .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
    .asel(asel), .bsel(bsel), .vsel(vsel), .write(write), .loadir(loadir),
    .loadpc(loadpc), .pc_clear(pc_clear), .msel(msel), .mwrite(mwrite), .halted(halted)
`ifdef CTRL_RETIRE_COUNT_EN
    , .retired(retired)
`endif
  );

  always #5 clk = ~clk;

  // {nsel, loada loadb loadc loads asel bsel, vsel, write loadir loadpc pc_clear msel mwrite halted}
  logic [17:0] obs;
  assign obs = {nsel, loada, loadb, loadc, loads, asel, bsel, vsel,
                write, loadir, loadpc, pc_clear, msel, mwrite, halted};

  localparam logic [17:0] E_RESET = {3'b000, 6'b000000, 2'b00, 7'b0001000};
  localparam logic [17:0] E_FA    = {3'b000, 6'b000000, 2'b00, 7'b0000000};
  localparam logic [17:0] E_FI    = {3'b000, 6'b000000, 2'b00, 7'b0100000};
  localparam logic [17:0] E_PI    = {3'b000, 6'b000000, 2'b00, 7'b0010000};
  localparam logic [17:0] E_DEC   = {3'b000, 6'b000000, 2'b00, 7'b0000000};
  localparam logic [17:0] E_WRIMM = {3'b001, 6'b000000, 2'b01, 7'b1000000};
  localparam logic [17:0] E_GETA  = {3'b001, 6'b100000, 2'b00, 7'b0000000};
  localparam logic [17:0] E_GETB  = {3'b100, 6'b010000, 2'b00, 7'b0000000};
  localparam logic [17:0] E_EXALU = {3'b000, 6'b001000, 2'b00, 7'b0000000};
  localparam logic [17:0] E_EXMOV = {3'b000, 6'b001010, 2'b00, 7'b0000000};
  localparam logic [17:0] E_EXCMP = {3'b000, 6'b000100, 2'b00, 7'b0000000};
  localparam logic [17:0] E_WRC   = {3'b010, 6'b000000, 2'b00, 7'b1000000};
  localparam logic [17:0] E_ADDR  = {3'b000, 6'b001001, 2'b00, 7'b0000000};
  localparam logic [17:0] E_MEMRD = {3'b000, 6'b000000, 2'b00, 7'b0000100};
  localparam logic [17:0] E_LDWR  = {3'b010, 6'b000000, 2'b10, 7'b1000100};
  localparam logic [17:0] E_GETD  = {3'b010, 6'b010000, 2'b00, 7'b0000000};
  localparam logic [17:0] E_MEMWR = {3'b000, 6'b000000, 2'b00, 7'b0000110};
  localparam logic [17:0] E_HALT  = {3'b000, 6'b000000, 2'b00, 7'b0000001};

  typedef struct {
    logic [17:0] v;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, act, req, $time);
    end
  endtask

  task automatic push(input logic [17:0] v, input string tag);
    exp_t e;
    e.v   = v;
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  // Monitor: one expected vector per clock while the scoreboard holds entries.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check(mon_e.tag, 32'(obs), 32'(mon_e.v));
    end
    if (reset === 1'b0)
      check("strobe_exclusive", 32'($countones({write, mwrite, loadir, loadpc}) <= 1), 32'd1);
  end

  // Wait for the monitor to consume every queued vector; polls after posedge or negedge.
  task automatic drain(input bit at_negedge);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      if (at_negedge) begin @(negedge clk); #1; end
      else begin @(posedge clk); #1; end
      n++;
    end
    if (exp_q.size() > 0) begin
      check("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  task automatic fetch(input string name);
    push(E_FA,  {name, "_fetch_addr"});
    push(E_FI,  {name, "_fetch_ir"});
    push(E_PI,  {name, "_pc_inc"});
    push(E_DEC, {name, "_decode"});
  endtask

  task automatic instr(input logic [2:0] opc, input logic [1:0] o, input string name);
    opcode = opc;
    op     = o;
    fetch(name);
    casez ({opc, o})
      5'b110_10: push(E_WRIMM, {name, "_wr_imm"});
      5'b110_00: begin
        push(E_GETB, {name, "_get_b"}); push(E_EXMOV, {name, "_exec"}); push(E_WRC, {name, "_wr_c"});
      end
      5'b101_01: begin
        push(E_GETA, {name, "_get_a"}); push(E_GETB, {name, "_get_b"}); push(E_EXCMP, {name, "_exec"});
      end
      5'b101_??: begin
        push(E_GETA, {name, "_get_a"}); push(E_GETB, {name, "_get_b"});
        push(E_EXALU, {name, "_exec"}); push(E_WRC, {name, "_wr_c"});
      end
      5'b011_00: begin
        push(E_GETA, {name, "_get_a"}); push(E_ADDR, {name, "_addr"});
        push(E_MEMRD, {name, "_mem_rd"}); push(E_LDWR, {name, "_ld_wr"});
      end
      5'b100_00: begin
        push(E_GETA, {name, "_get_a"}); push(E_ADDR, {name, "_addr"});
        push(E_GETD, {name, "_get_d"}); push(E_MEMWR, {name, "_mem_wr"});
      end
      default: ;
    endcase
    drain(1'b0);
  endtask

  initial begin
    reset  = 1'b1;
    opcode = 3'b000;
    op     = 2'b00;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("reset_hold", 32'(obs), 32'(E_RESET));
    reset = 1'b0;
    push(E_RESET, "rst_release");

    instr(3'b110, 2'b10, "mov_imm");
    instr(3'b110, 2'b00, "mov_reg");
    instr(3'b101, 2'b00, "add");
    instr(3'b101, 2'b11, "mvn");
    instr(3'b101, 2'b01, "cmp");
    instr(3'b011, 2'b00, "ldr");
    instr(3'b100, 2'b00, "str");
    instr(3'b001, 2'b00, "nop_001");
    instr(3'b110, 2'b01, "nop_110_01");
`ifdef CTRL_RETIRE_COUNT_EN
    check("retired_after_9", 32'(retired), 32'd9);
`endif

    // Reset asserted mid-GET_B must take effect without a clock edge
    opcode = 3'b110;
    op     = 2'b00;
    fetch("mid_getb");
    push(E_GETB, "mid_getb_get_b");
    drain(1'b1);
    reset = 1'b1;
    #1;
    check("async_reset_mid_getb", 32'(obs), 32'(E_RESET));
`ifdef CTRL_RETIRE_COUNT_EN
    check("retired_cleared", 32'(retired), 32'd0);
`endif
    @(posedge clk); #1;
    reset = 1'b0;
    push(E_RESET, "rst_release2");
    instr(3'b110, 2'b10, "mov_imm2");

    // HALT is sticky for 20 clocks, then reset restarts the machine
    opcode = 3'b111;
    op     = 2'b10;
    fetch("halt");
    for (int i = 0; i < 20; i++) push(E_HALT, "halt_hold");
    drain(1'b0);
    reset = 1'b1;
    push(E_RESET, "halt_reset");
    @(posedge clk); #1;
    reset = 1'b0;
    push(E_RESET, "halt_rst_release");
    instr(3'b101, 2'b00, "add_after_halt");

`ifdef CTRL_RETIRE_COUNT_EN
    check("retired_after_halt", 32'(retired), 32'd1);
    force dut.retired_r = 16'hFFFF;
    #1;
    release dut.retired_r;
    instr(3'b110, 2'b10, "mov_imm_wrap");
    check("retired_wrap", 32'(retired), 32'd0);
    instr(3'b001, 2'b00, "nop_count");
    check("retired_nop", 32'(retired), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
